// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Performs a chain of up to MAX_DEPTH memory accesses for one request. The
// first access goes to base_addr. Every access except the last is a read, and
// the data it returns becomes the address of the next access. The last access
// is a read into rdata, or a write of the latched wdata.
//
// Parameters: WIDTH (data/address width), MAX_DEPTH (max accesses per
//             operation), TIMEOUT (watchdog limit in cycles).
// Ports:      clk, reset (synchronous, active-high)
//             start, num_access, is_store, base_addr, wdata  - request
//             busy, done, error, rdata                      - status/result
//             mem_address, mem_wdata, mem_read, mem_write   - memory request
//             mem_resp, mem_rdata                           - memory response
// Optional:   `define MEM_TIMEOUT_EN to enable the response watchdog. Without
//             it, error is tied low and an access waits for mem_resp forever.
module mem_access_sequencer #(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned MAX_DEPTH = 2,
    parameter  int unsigned TIMEOUT   = 255,
    localparam int unsigned CNT_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_access,
    input  logic             is_store,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             store_q;
    logic [WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0] num_clamped;
    logic             strobe;

    // Requests deeper than the sequencer supports are truncated
    assign num_clamped = (num_access > MAX_CNT) ? MAX_CNT : num_access;
    assign strobe      = mem_read | mem_write;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            error_q;

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wd_cnt      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            error_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        store_q <= is_store;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (num_clamped == '0) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt         <= num_clamped;
                            mem_address <= base_addr;
                            // A single-access store goes straight to the write
                            if (num_clamped == ONE_CNT && is_store) begin
                                mem_write <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                mem_read <= 1'b1;
                            end
`ifdef MEM_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                            state <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    if (strobe) begin
                        if (mem_resp) begin
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                            if (cnt == ONE_CNT) begin
                                cnt   <= '0;
                                done  <= 1'b1;
                                state <= S_DONE;
                                if (!store_q) begin
                                    rdata <= mem_rdata;
                                end
                            end else begin
                                // Pointer returned by this read addresses the next access
                                cnt         <= cnt - ONE_CNT;
                                mem_address <= mem_rdata;
                            end
                        end
`ifdef MEM_TIMEOUT_EN
                        else if (wd_cnt == WD_LAST) begin
                            mem_read  <= 1'b0;
                            mem_write <= 1'b0;
                            busy      <= 1'b0;
                            error_q   <= 1'b1;
                            cnt       <= '0;
                            wd_cnt    <= '0;
                            state     <= S_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
`endif
                    end else begin
                        // Gap cycle after a response: launch the next access
                        if (cnt == ONE_CNT && store_q) begin
                            mem_write <= 1'b1;
                            mem_wdata <= wdata_q;
                        end else begin
                            mem_read <= 1'b1;
                        end
`ifdef MEM_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cnt       <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: random pointer-chasing operations against
// a memory whose contents are a fixed function of the address, plus directed
// cases for zero/over-depth requests, ignored starts, reset and the watchdog.
module tb_mem_access_sequencer;

    localparam int unsigned W    = 16;
    localparam int unsigned MAXD = 2;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CW   = $clog2(MAXD + 1);

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_access;
    logic          is_store;
    logic [W-1:0]  base_addr;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [W-1:0]  rdata;
    logic [W-1:0]  mem_address;
    logic [W-1:0]  mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic          mem_resp;
    logic [W-1:0]  mem_rdata;

    mem_access_sequencer #(
        .WIDTH    (W),
        .MAX_DEPTH(MAXD),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_access (num_access),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .rdata      (rdata),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] addr;
        logic         wr;
        logic [W-1:0] wdata;
    } acc_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    acc_t         acc_q[$];
    logic [W-1:0] mem_ovr[logic [W-1:0]];
    logic [W-1:0] exp_rdata = '0;
    int           done_cnt   = 0;
    int           strobe_cyc = 0;
    int           fix_dly    = -1;
    bit           resp_en    = 1'b1;
    bit           spur_en    = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: a few pinned locations, otherwise a hash of the address
    function automatic logic [W-1:0] rd_mem(input logic [W-1:0] a);
        logic [W-1:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = W'(a * 16'd40503 + 16'd12345);
        return h ^ 16'h3C5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Memory responder and protocol monitor, acting 1 time unit after each edge
    initial begin : responder
        int   waited;
        int   cur_dly;
        logic prev_strobe, prev_resp, prev_rd, prev_wr;
        logic [W-1:0] prev_addr, prev_wdata;
        logic strobe;
        waited = 0; cur_dly = 0;
        prev_strobe = 1'b0; prev_resp = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
        prev_addr = '0; prev_wdata = '0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            strobe = mem_read | mem_write;
            if (done) done_cnt++;
            if (strobe) strobe_cyc++;
            check("strobe_excl", 32'(mem_read & mem_write), 0);
            if (!busy || done) check("strobe_when_idle_done", 32'(strobe), 0);
            if (!reset && prev_strobe && !prev_resp && !error) begin
                check("hold_read", 32'(mem_read), 32'(prev_rd));
                check("hold_write", 32'(mem_write), 32'(prev_wr));
                check("hold_addr", 32'(mem_address), 32'(prev_addr));
                if (prev_wr) check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
            end
            if (!reset && prev_strobe && prev_resp) check("gap_after_resp", 32'(strobe), 0);

            if (strobe) begin
                if (resp_en && waited >= cur_dly) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_read ? rd_mem(mem_address) : W'($urandom);
                    acc_q.push_back('{addr: mem_address, wr: mem_write, wdata: mem_wdata});
                    waited = 0;
                end else begin
                    mem_resp  = 1'b0;
                    mem_rdata = W'($urandom);
                    waited++;
                end
            end else begin
                waited    = 0;
                cur_dly   = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                mem_resp  = spur_en && ($urandom_range(0, 3) == 0);
                mem_rdata = W'($urandom);
            end
            prev_strobe = strobe;
            prev_resp   = mem_resp;
            prev_rd     = mem_read;
            prev_wr     = mem_write;
            prev_addr   = mem_address;
            prev_wdata  = mem_wdata;
        end
    end

    task automatic scramble();
        num_access = CW'($urandom_range(0, 3));
        is_store   = 1'($urandom_range(0, 1));
        base_addr  = W'($urandom);
        wdata      = W'($urandom);
    endtask

    // One operation: predicts the access chain, runs it, compares the outcome
    task automatic run_op(input logic [W-1:0] b, input int n, input bit st,
                          input logic [W-1:0] wd, input bit rep, input int exp_cyc);
        acc_t exp_q[$];
        logic [W-1:0] a;
        int   n_eff;
        int   cyc;
        bit   got;
        n_eff = (n > int'(MAXD)) ? int'(MAXD) : n;
        a = b;
        for (int i = 0; i < n_eff; i++) begin
            bit last;
            last = (i == n_eff - 1);
            exp_q.push_back('{addr: a, wr: last && st, wdata: wd});
            if (!last) a = rd_mem(a);
            else if (!st) exp_rdata = rd_mem(a);
        end

        acc_q.delete();
        done_cnt   = 0;
        strobe_cyc = 0;
        start      = 1'b1;
        num_access = CW'(n);
        is_store   = st;
        base_addr  = b;
        wdata      = wd;
        tick();
        if (n_eff == 0) begin
            check("zero_done_cycle1", 32'(done), 1);
        end else begin
            check("first_strobe", 32'(mem_read | mem_write), 1);
            check("first_is_write", 32'(mem_write), 32'(n_eff == 1 && st));
            check("first_addr", 32'(mem_address), 32'(b));
        end
        if (rep) begin
            start      = 1'b1;
            num_access = CW'(1);
            is_store   = 1'b0;
            base_addr  = 16'hFFFE;
        end else begin
            start = 1'b0;
            scramble();
        end
        got = done;
        cyc = 1;
        while (!got && cyc < 100) begin
            tick();
            start = 1'b0;
            scramble();
            cyc++;
            got = done;
        end
        check("done_seen", 32'(got), 1);
        if (exp_cyc > 0) check("done_cycle", 32'(cyc), 32'(exp_cyc));
        check("access_count", 32'(acc_q.size()), 32'(n_eff));
        for (int i = 0; i < n_eff && i < acc_q.size(); i++) begin
            check($sformatf("acc%0d_addr", i), 32'(acc_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("acc%0d_wr", i), 32'(acc_q[i].wr), 32'(exp_q[i].wr));
            if (exp_q[i].wr) check($sformatf("acc%0d_wdata", i), 32'(acc_q[i].wdata), 32'(exp_q[i].wdata));
        end
        check("rdata", 32'(rdata), 32'(exp_rdata));
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 0);
        check("busy_after_done", 32'(busy), 0);
        check("done_pulses", 32'(done_cnt), 1);
        if (n_eff == 0) check("zero_no_strobe", 32'(strobe_cyc), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        reset = 1'b1;
        start = 1'b0;
        num_access = '0;
        is_store = 1'b0;
        base_addr = '0;
        wdata = '0;
        mem_ovr[16'h0040] = 16'hBEEF;
        mem_ovr[16'h0100] = 16'h2000;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        reset = 1'b0;
        tick();

        // Single read, response three cycles into the access
        fix_dly = 2;
        run_op(16'h0040, 1, 1'b0, 16'h0000, 1'b0, 4);
        check("single_read_value", 32'(rdata), 32'hBEEF);

        // Read-then-write through a pointer
        fix_dly = -1;
        run_op(16'h0100, 2, 1'b1, 16'h1234, 1'b0, -1);

        // Zero accesses, with a start pulse landing in the DONE cycle
        run_op(16'h0055, 0, 1'b0, 16'h0000, 1'b1, 1);

        // Over-depth request is truncated
        run_op(16'h0200, 3, 1'b0, 16'h0000, 1'b0, -1);
        run_op(16'h0204, 3, 1'b1, 16'hA5A5, 1'b0, -1);

        // Start re-pulsed while an access is outstanding
        fix_dly = 3;
        run_op(16'h0300, 2, 1'b0, 16'h0000, 1'b1, -1);
        fix_dly = -1;

        // Reset while a read waits for its response
        resp_en  = 1'b0;
        done_cnt = 0;
        start = 1'b1; num_access = CW'(1); is_store = 1'b0; base_addr = 16'h0040;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rst_mid_waiting", 32'(mem_read), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rdata = '0;
        check("rst_mid_read", 32'(mem_read), 0);
        check("rst_mid_write", 32'(mem_write), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(done), 0);
        check("rst_mid_rdata", 32'(rdata), 0);
        tick();
        tick();
        check("rst_mid_no_done", 32'(done_cnt), 0);
        check("rst_mid_stays_idle", 32'(busy), 0);
        resp_en = 1'b1;

        // Reset wins over a simultaneous start
        start = 1'b1; num_access = CW'(2); reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        check("rst_prio_busy", 32'(busy), 0);
        check("rst_prio_strobe", 32'(mem_read | mem_write), 0);
        tick();
        check("rst_prio_still_idle", 32'(busy), 0);

`ifdef MEM_TIMEOUT_EN
        // Unanswered access is abandoned by the watchdog
        begin
            int  sc;
            bit  err_seen;
            logic [W-1:0] rd_before;
            resp_en  = 1'b0;
            spur_en  = 1'b0;
            done_cnt = 0;
            rd_before = rdata;
            start = 1'b1; num_access = CW'(2); is_store = 1'b0; base_addr = 16'h0777;
            tick();
            start = 1'b0;
            sc = (mem_read | mem_write) ? 1 : 0;
            err_seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (error) begin
                    err_seen = 1'b1;
                    break;
                end
                if (mem_read | mem_write) sc++;
            end
            check("tmo_error_seen", 32'(err_seen), 1);
            check("tmo_strobe_cycles", 32'(sc), TMO);
            check("tmo_strobe_dropped", 32'(mem_read | mem_write), 0);
            check("tmo_busy", 32'(busy), 0);
            check("tmo_rdata", 32'(rdata), 32'(rd_before));
            tick();
            check("tmo_error_pulse", 32'(error), 0);
            check("tmo_no_done", 32'(done_cnt), 0);
            resp_en = 1'b1;
            spur_en = 1'b1;
        end
`endif

        // Random operations
        for (int k = 0; k < 60; k++) begin
            run_op(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   W'($urandom), ($urandom_range(0, 3) == 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data/address width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 2: maximum memory accesses per operation (1 = direct, 2 = single indirection, ...).
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles to wait for mem_resp before abort (used only with MEM_TIMEOUT_EN).
REQ-004 SHALL derive CNT_W = $clog2(MAX_DEPTH+1).
REQ-005 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  request pulse; sampled only in IDLE.
REQ-009 num_access  input  CNT_W  accesses requested (0..MAX_DEPTH).
REQ-010 is_store  input  1  final access is a write (1) or read (0).
REQ-011 base_addr  input  WIDTH  address of first access.
REQ-012 wdata  input  WIDTH  store data for final write.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 error  output  1  one-cycle timeout pulse.
REQ-016 rdata  output  WIDTH  data returned by final read.
REQ-017 mem_address / mem_wdata  output  WIDTH  memory address / write data.
REQ-018 mem_read / mem_write  output  1  memory request strobes.
REQ-019 mem_resp  input  1  memory response; mem_rdata  input  WIDTH  read data.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE; transitions IDLE->ACCESS (start, num_access>0), IDLE->DONE (start, num_access==0), ACCESS->ACCESS (mem_resp, accesses remain), ACCESS->DONE (mem_resp on last access), DONE->IDLE unconditionally.
REQ-021 SHALL latch num_access, is_store, base_addr, wdata on accepted start; later input changes ignored until IDLE.
REQ-022 SHALL clamp num_access > MAX_DEPTH to MAX_DEPTH.
REQ-023 SHALL issue first request in cycle after start sample (latency 1), mem_address = latched base_addr.
REQ-024 Accesses 1..N-1 SHALL be reads; on mem_resp, mem_rdata becomes address of next access.
REQ-025 Access N SHALL be a read if is_store=0 (mem_rdata captured into rdata on mem_resp) or a write of latched wdata if is_store=1 (rdata unchanged).
REQ-026 Request strobe and mem_address/mem_wdata SHALL be held stable until and including the mem_resp cycle; strobe low in the following cycle for at least one cycle (no back-to-back strobe without a low cycle between accesses).
REQ-027 mem_read and mem_write SHALL never be high simultaneously; both low in IDLE and DONE.
REQ-028 done SHALL be high exactly in DONE state (one cycle after final mem_resp; one cycle after start when num_access==0, with no memory activity).
REQ-029 start during busy SHALL be ignored; start in DONE cycle ignored.
REQ-030 mem_resp while no strobe is high SHALL be ignored.
REQ-031 Access counter SHALL count down from N to 1 with no wrap; counter reaches 0 only on exit from ACCESS.

Reset
REQ-032 On reset: state IDLE, busy=0, done=0, error=0, mem_read=0, mem_write=0, rdata=0, mem_address=0, mem_wdata=0, counters 0.
REQ-033 Reset mid-operation SHALL abort immediately; strobes low in cycle after the reset edge; no done or error pulse for the aborted operation.
REQ-034 reset SHALL take priority over start and mem_resp in the same cycle.

Configuration
REQ-035 Macro MEM_TIMEOUT_EN defined: watchdog counts cycles a strobe is high without mem_resp; on reaching TIMEOUT, SHALL drop strobe, pulse error for one cycle, return to IDLE, no done, rdata unchanged; counter cleared on each mem_resp and each new access.
REQ-036 Macro MEM_TIMEOUT_EN undefined: no watchdog logic, error tied to 0, ACCESS waits indefinitely for mem_resp.

Verification
REQ-037 num_access=1, is_store=0, base_addr=0x0040, mem_rdata=0xBEEF after 3 cycles -> mem_read at 0x0040 from cycle 1, done one cycle after resp, rdata=0xBEEF.
REQ-038 num_access=2, is_store=1, base_addr=0x0100, first read returns 0x2000, wdata=0x1234 -> read 0x0100, then mem_write at 0x2000 with mem_wdata=0x1234, single done pulse.
REQ-039 num_access=0 -> done in cycle 1, mem_read/mem_write never asserted; num_access=3 with MAX_DEPTH=2 -> exactly two accesses.
REQ-040 start re-pulsed with base_addr=0xFFFE during active access -> ignored, original address sequence unchanged.
REQ-041 reset asserted while mem_read high waiting for resp -> strobes low, busy=0 next cycle, no done.
REQ-042 MEM_TIMEOUT_EN, TIMEOUT=8, mem_resp never asserted -> error pulses after 8 strobe cycles, busy=0, done never asserted.
